wash_sequencer: RTL and testbench



---
 rtl/wash_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-program controller: top-level state, program/weight settings, stage
// sequencing and per-stage second timer. Define WASH_BUZZER_EN to add the buzzer output.
module wash_sequencer #(
  parameter int BEGIN_T    = 2,
  parameter int FINISH_T   = 3,
  parameter int WASH_T     = 9,
  parameter int RINSE_T    = 6,
  parameter int DRAIN_T    = 3,
  parameter int SPIN_T     = 4,
  parameter int DEF_WEIGHT = 3
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       second,
  input  logic       power_key,
  input  logic       start_key,
  input  logic       mode_key,
  input  logic       weight_key,
  input  logic       lid_open,
  output logic [2:0] state,
  output logic [9:0] data,
  output logic [2:0] shinning,
  output logic [5:0] inLeft,
  output logic [5:0] inMiddle,
`ifdef WASH_BUZZER_EN
  output logic [5:0] inRight,
  output logic       buzzer
`else
  output logic [5:0] inRight
`endif
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BEGIN  = 3'd1,
    ST_SET    = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  localparam logic [5:0] BEGIN_D  = 6'(BEGIN_T);
  localparam logic [5:0] FINISH_D = 6'(FINISH_T);
  localparam logic [5:0] WASH_D   = 6'(WASH_T);
  localparam logic [5:0] RINSE_D  = 6'(RINSE_T);
  localparam logic [5:0] DRAIN_D  = 6'(DRAIN_T);
  localparam logic [5:0] SPIN_D   = 6'(SPIN_T);
  localparam logic [3:0] DEF_W    = 4'(DEF_WEIGHT);

  state_t     state_q, state_d;
  logic [1:0] prog_q, prog_d;
  logic [3:0] weight_q, weight_d;
  logic [2:0] stage_q, stage_d;
  logic [5:0] timer_q, timer_d;
  logic       second_q;
  logic       tick;

  logic [9:0] data_q, data_d;
  logic [2:0] shin_q, shin_d;
  logic [5:0] left_q, left_d;
  logic [5:0] mid_q, mid_d;
  logic [5:0] right_q, right_d;

  logic [7:0] mask_q, mask_d;
  logic [2:0] first_stage, next_stage;
  logic       has_next;
  logic       active_d;

  function automatic logic [7:0] prog_mask(input logic [1:0] p);
    case (p)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hC3;
      2'd2:    return 8'hFC;
      default: return 8'hC0;
    endcase
  endfunction

  // Water-fill stages scale with the load weight; the rest are fixed.
  function automatic logic [5:0] stage_dur(input logic [2:0] s, input logic [3:0] w);
    case (s)
      3'd0, 3'd4: return {2'b00, w};
      3'd1:       return WASH_D;
      3'd2, 3'd6: return DRAIN_D;
      3'd3, 3'd7: return SPIN_D;
      default:    return RINSE_D;
    endcase
  endfunction

  assign tick   = second & ~second_q;
  assign mask_q = prog_mask(prog_q);
  assign mask_d = prog_mask(prog_d);

  // Descending scan so the lowest qualifying stage is the one left standing.
  always_comb begin
    first_stage = '0;
    next_stage  = '0;
    has_next    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_stage = 3'(i);
        if (i > int'(stage_q)) begin
          has_next   = 1'b1;
          next_stage = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    weight_d = weight_q;
    stage_d  = stage_q;
    timer_d  = timer_q;
    if (power_key) begin
      if (state_q == ST_OFF) begin
        state_d = ST_BEGIN;
        timer_d = BEGIN_D;
      end else begin
        state_d = ST_OFF;
        timer_d = '0;
      end
    end else begin
      case (state_q)
        ST_BEGIN: begin
          if (tick) begin
            if (timer_q == 6'd1) begin
              state_d  = ST_SET;
              prog_d   = 2'd0;
              weight_d = DEF_W;
              timer_d  = '0;
            end else begin
              timer_d = timer_q - 6'd1;
            end
          end
        end
        ST_SET: begin
          if (start_key) begin
            // Stage and duration load even with the lid open, so a later resume starts cleanly.
            stage_d = first_stage;
            timer_d = stage_dur(first_stage, weight_q);
            state_d = lid_open ? ST_ERROR : ST_RUN;
          end else if (mode_key) begin
            prog_d = prog_q + 2'd1;
          end else if (weight_key) begin
            weight_d = (weight_q >= 4'd9) ? 4'd1 : weight_q + 4'd1;
          end
        end
        ST_RUN: begin
          if (lid_open) begin
            state_d = ST_ERROR;
          end else if (start_key) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (timer_q > 6'd1) begin
              timer_d = timer_q - 6'd1;
            end else if (has_next) begin
              stage_d = next_stage;
              timer_d = stage_dur(next_stage, weight_q);
            end else begin
              state_d = ST_FINISH;
              timer_d = FINISH_D;
            end
          end
        end
        ST_PAUSE: begin
          if (start_key) state_d = lid_open ? ST_ERROR : ST_RUN;
        end
        ST_ERROR: begin
          if (!lid_open) state_d = ST_PAUSE;
        end
        ST_FINISH: begin
          if (tick) begin
            if (timer_q == 6'd1) begin
              state_d = ST_OFF;
              timer_d = '0;
            end else begin
              timer_d = timer_q - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are derived from next-state values and registered alongside it.
  always_comb begin
    active_d = (state_d == ST_RUN) || (state_d == ST_PAUSE) || (state_d == ST_ERROR);
    data_d    = '0;
    data_d[8] = (state_d != ST_OFF);
    data_d[9] = (state_d == ST_SET);
    for (int i = 0; i < 8; i++) begin
      if (state_d == ST_SET) begin
        data_d[7-i] = mask_d[i];
      end else if (active_d && (i >= int'(stage_d))) begin
        data_d[7-i] = mask_d[i];
      end
    end
    shin_d  = active_d ? stage_d : 3'd0;
    left_d  = (active_d || state_d == ST_SET) ? {2'b00, weight_d} : 6'd0;
    mid_d   = (active_d || state_d == ST_SET) ? {4'b0000, prog_d} : 6'd0;
    right_d = active_d ? timer_d : 6'd0;
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      prog_q   <= 2'd0;
      weight_q <= DEF_W;
      stage_q  <= 3'd0;
      timer_q  <= 6'd0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prog_q   <= prog_d;
      weight_q <= weight_d;
      stage_q  <= stage_d;
      timer_q  <= timer_d;
      second_q <= second;
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      shin_q  <= '0;
      left_q  <= '0;
      mid_q   <= '0;
      right_q <= '0;
    end else begin
      data_q  <= data_d;
      shin_q  <= shin_d;
      left_q  <= left_d;
      mid_q   <= mid_d;
      right_q <= right_d;
    end
  end

  assign state    = state_q;
  assign data     = data_q;
  assign shinning = shin_q;
  assign inLeft   = left_q;
  assign inMiddle = mid_q;
  assign inRight  = right_q;

`ifdef WASH_BUZZER_EN
  logic [1:0] buzz_cnt_q, buzz_cnt_d;
  logic       buzzer_q, buzzer_d;

  // Counts the two finish-state ticks the buzzer sounds for.
  always_comb begin
    buzz_cnt_d = buzz_cnt_q;
    if (state_d != ST_FINISH) begin
      buzz_cnt_d = 2'd0;
    end else if (state_q != ST_FINISH) begin
      buzz_cnt_d = 2'd2;
    end else if (tick && buzz_cnt_q != 2'd0) begin
      buzz_cnt_d = buzz_cnt_q - 2'd1;
    end
    buzzer_d = ((state_d == ST_FINISH) && (buzz_cnt_d != 2'd0)) ||
               ((state_d == ST_ERROR) && second);
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt_q <= 2'd0;
      buzzer_q   <= 1'b0;
    end else begin
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: vector table, hand-written lid/reset sequences and
// randomized keys checked against a behavioural model of the washing program.
module tb_wash_sequencer;
  localparam int W        = 34;
  localparam int BEGIN_T  = 2;
  localparam int FINISH_T = 3;
  localparam int DEF_WT   = 3;

  logic       cp = 1'b0;
  logic       rst_n;
  logic       second, power_key, start_key, mode_key, weight_key, lid_open;
  logic [2:0] state;
  logic [9:0] data;
  logic [2:0] shinning;
  logic [5:0] inLeft, inMiddle, inRight;
`ifdef WASH_BUZZER_EN
  logic       buzzer;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Behavioural model state
  int m_state, m_prog, m_weight, m_stage, m_timer, m_bcnt;
  bit m_prev, m_buzz;

  typedef struct {
    logic [3:0] keys;   // {power, start, mode, weight}
    logic       lid;
    logic       tick;
    logic [2:0] st;
    logic [9:0] data;
    logic [2:0] shin;
    logic [5:0] left;
    logic [5:0] mid;
    logic [5:0] right;
  } row_t;
  row_t rows[$];

  wash_sequencer dut (
    .cp(cp), .rst_n(rst_n), .second(second), .power_key(power_key),
    .start_key(start_key), .mode_key(mode_key), .weight_key(weight_key),
    .lid_open(lid_open), .state(state), .data(data), .shinning(shinning),
    .inLeft(inLeft), .inMiddle(inMiddle),
`ifdef WASH_BUZZER_EN
    .inRight(inRight), .buzzer(buzzer)
`else
    .inRight(inRight)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 cp = ~cp;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pmask(input int p);
    case (p)
      0:       return 8'hFF;
      1:       return 8'hC3;
      2:       return 8'hFC;
      default: return 8'hC0;
    endcase
  endfunction

  function automatic int dur(input int s);
    case (s)
      0, 4:    return m_weight;
      1:       return 9;
      2, 6:    return 3;
      3, 7:    return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int first_after(input int from);
    logic [7:0] m;
    m = pmask(m_prog);
    for (int s = from + 1; s < 8; s++) if (m[s]) return s;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prog = 0; m_weight = DEF_WT; m_stage = 0; m_timer = 0;
    m_prev = 1'b0; m_bcnt = 0; m_buzz = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] k, input logic lid, input logic sec);
    bit tick;
    int old, nx;
    tick = sec && !m_prev;
    m_prev = sec;
    old = m_state;
    if (k[3]) begin
      if (m_state == 0) begin m_state = 1; m_timer = BEGIN_T; end
      else begin m_state = 0; m_timer = 0; end
    end else begin
      case (m_state)
        1: if (tick) begin
             if (m_timer == 1) begin m_state = 2; m_prog = 0; m_weight = DEF_WT; end
             else m_timer--;
           end
        2: if (k[2]) begin
             m_stage = first_after(-1);
             m_timer = dur(m_stage);
             m_state = lid ? 4 : 3;
           end else if (k[1]) m_prog = (m_prog + 1) % 4;
           else if (k[0]) m_weight = m_weight % 9 + 1;
        3: if (lid) m_state = 4;
           else if (k[2]) m_state = 5;
           else if (tick) begin
             if (m_timer > 1) m_timer--;
             else begin
               nx = first_after(m_stage);
               if (nx < 0) begin m_state = 6; m_timer = FINISH_T; end
               else begin m_stage = nx; m_timer = dur(nx); end
             end
           end
        4: if (!lid) m_state = 5;
        5: if (k[2]) m_state = lid ? 4 : 3;
        6: if (tick) begin
             if (m_timer == 1) m_state = 0;
             else m_timer--;
           end
        default: ;
      endcase
    end
    if (m_state != 6) m_bcnt = 0;
    else if (old != 6) m_bcnt = 2;
    else if (tick && m_bcnt > 0) m_bcnt--;
    m_buzz = (m_state == 6 && m_bcnt > 0) || (m_state == 4 && sec);
  endtask

  function automatic logic [W-1:0] model_out();
    logic [9:0] d;
    logic [7:0] m;
    bit act, st_set;
    int shin, left, mid, right;
    m = pmask(m_prog);
    act = (m_state == 3) || (m_state == 4) || (m_state == 5);
    st_set = (m_state == 2);
    d = '0;
    d[8] = (m_state != 0);
    d[9] = st_set;
    for (int i = 0; i < 8; i++) begin
      if (st_set) d[7-i] = m[i];
      else if (act && i >= m_stage) d[7-i] = m[i];
    end
    shin  = act ? m_stage : 0;
    left  = (act || st_set) ? m_weight : 0;
    mid   = (act || st_set) ? m_prog : 0;
    right = act ? m_timer : 0;
    return {3'(m_state), d, 3'(shin), 6'(left), 6'(mid), 6'(right)};
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] k, input logic lid, input logic sec);
    logic [W-1:0] e;
    power_key = k[3]; start_key = k[2]; mode_key = k[1]; weight_key = k[0];
    lid_open = lid; second = sec;
    model_step(k, lid, sec);
    exp_q.push_back(model_out());
    @(posedge cp);
    #1;
    e = exp_q.pop_front();
    chk("cyc_state", 32'(state), 32'(e[33:31]));
    chk("cyc_data", 32'(data), 32'(e[30:21]));
    chk("cyc_shinning", 32'(shinning), 32'(e[20:18]));
    chk("cyc_inLeft", 32'(inLeft), 32'(e[17:12]));
    chk("cyc_inMiddle", 32'(inMiddle), 32'(e[11:6]));
    chk("cyc_inRight", 32'(inRight), 32'(e[5:0]));
`ifdef WASH_BUZZER_EN
    chk("cyc_buzzer", 32'(buzzer), 32'(m_buzz));
`endif
    power_key = 1'b0; start_key = 1'b0; mode_key = 1'b0; weight_key = 1'b0;
  endtask

  task automatic add(input logic [3:0] k, input logic lid, input logic tk, input logic [2:0] st,
                     input logic [9:0] d, input logic [2:0] sh, input logic [5:0] l,
                     input logic [5:0] md, input logic [5:0] r);
    row_t x;
    x.keys = k; x.lid = lid; x.tick = tk; x.st = st; x.data = d;
    x.shin = sh; x.left = l; x.mid = md; x.right = r;
    rows.push_back(x);
  endtask

  localparam logic [3:0] KN = 4'b0000, KP = 4'b1000, KS = 4'b0100, KM = 4'b0010, KW = 4'b0001;

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0; second = 1'b0; lid_open = 1'b0;
    power_key = 1'b0; start_key = 1'b0; mode_key = 1'b0; weight_key = 1'b0;
    model_reset();

    // Power-up, program 3 with weight wrap, full run to shutdown
    add(KP, 0, 0, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 2, 10'h3FF, 0, 3, 0, 0);
    add(KM, 0, 0, 2, 10'h3C3, 0, 3, 1, 0);
    add(KM, 0, 0, 2, 10'h33F, 0, 3, 2, 0);
    add(KM, 0, 0, 2, 10'h303, 0, 3, 3, 0);
    for (int w = 4; w <= 10; w++) add(KW, 0, 0, 2, 10'h303, 0, 6'((w > 9) ? 1 : w), 3, 0);
    add(KS, 0, 0, 3, 10'h103, 6, 1, 3, 3);
    add(KN, 0, 1, 3, 10'h103, 6, 1, 3, 2);
    add(KN, 0, 1, 3, 10'h103, 6, 1, 3, 1);
    add(KN, 0, 1, 3, 10'h101, 7, 1, 3, 4);
    add(KN, 0, 1, 3, 10'h101, 7, 1, 3, 3);
    add(KN, 0, 1, 3, 10'h101, 7, 1, 3, 2);
    add(KN, 0, 1, 3, 10'h101, 7, 1, 3, 1);
    add(KN, 0, 1, 6, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 6, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 6, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 0, 10'h000, 0, 0, 0, 0);
    // Program 0: lid error, pause, resume, stage advance, start+mode pause
    add(KP, 0, 0, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 2, 10'h3FF, 0, 3, 0, 0);
    add(KS, 0, 0, 3, 10'h1FF, 0, 3, 0, 3);
    add(KN, 0, 1, 3, 10'h1FF, 0, 3, 0, 2);
    add(KN, 1, 0, 4, 10'h1FF, 0, 3, 0, 2);
    add(KN, 0, 0, 5, 10'h1FF, 0, 3, 0, 2);
    add(KS, 0, 0, 3, 10'h1FF, 0, 3, 0, 2);
    add(KN, 0, 1, 3, 10'h1FF, 0, 3, 0, 1);
    add(KN, 0, 1, 3, 10'h17F, 1, 3, 0, 9);
    add(KS | KM, 0, 0, 5, 10'h17F, 1, 3, 0, 9);
    add(KN, 0, 1, 5, 10'h17F, 1, 3, 0, 9);
    add(KS, 0, 0, 3, 10'h17F, 1, 3, 0, 9);
    add(KP, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    // Key priority corners
    add(KP, 0, 0, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 1, 10'h100, 0, 0, 0, 0);
    add(KN, 0, 1, 2, 10'h3FF, 0, 3, 0, 0);
    add(KS | KM, 0, 0, 3, 10'h1FF, 0, 3, 0, 3);
    add(KP | KS, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    add(KS, 0, 0, 0, 10'h000, 0, 0, 0, 0);

    repeat (2) @(posedge cp);
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_shinning", 32'(shinning), 0);
    chk("reset_inLeft", 32'(inLeft), 0);
    chk("reset_inMiddle", 32'(inMiddle), 0);
    chk("reset_inRight", 32'(inRight), 0);
`ifdef WASH_BUZZER_EN
    chk("reset_buzzer", 32'(buzzer), 0);
`endif
    rst_n = 1'b1;

    for (int k = 0; k < rows.size(); k++) begin
      cycle(rows[k].keys, rows[k].lid, rows[k].tick);
      cycle(KN, rows[k].lid, 1'b0);
      chk($sformatf("row%0d_state", k), 32'(state), 32'(rows[k].st));
      chk($sformatf("row%0d_data", k), 32'(data), 32'(rows[k].data));
      chk($sformatf("row%0d_shinning", k), 32'(shinning), 32'(rows[k].shin));
      chk($sformatf("row%0d_inLeft", k), 32'(inLeft), 32'(rows[k].left));
      chk($sformatf("row%0d_inMiddle", k), 32'(inMiddle), 32'(rows[k].mid));
      chk($sformatf("row%0d_inRight", k), 32'(inRight), 32'(rows[k].right));
    end

    // Start in set with the lid open, close it, resume with the loaded stage
    cycle(KP, 0, 0);
    for (int t = 0; t < 2; t++) begin cycle(KN, 0, 1); cycle(KN, 0, 0); end
    cycle(KW, 0, 0);
    cycle(KS, 1, 0);
    chk("lidset_state", 32'(state), 4);
    chk("lidset_inRight", 32'(inRight), 4);
    cycle(KN, 0, 0);
    chk("lidset_pause", 32'(state), 5);
    cycle(KS, 0, 0);
    chk("lidset_run", 32'(state), 3);
    chk("lidset_run_inRight", 32'(inRight), 4);
    cycle(KN, 0, 1);
    chk("lidset_tick_inRight", 32'(inRight), 3);
    cycle(KN, 0, 0);

    // Asynchronous reset in the middle of a run
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_data", 32'(data), 0);
    chk("async_inRight", 32'(inRight), 0);
    chk("async_inLeft", 32'(inLeft), 0);
    model_reset();
    @(posedge cp);
    #1;
    rst_n = 1'b1;
    cycle(KN, 0, 0);
    cycle(KP, 0, 0);
    chk("async_restart", 32'(state), 1);

    // Randomized keys, lid and second period against the model
    begin
      int half, cnt;
      logic sec, lid;
      half = 2; cnt = 0; sec = 1'b0; lid = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        logic [3:0] k;
        int r;
        k = KN;
        r = $urandom_range(0, 199);
        if ($urandom_range(0, 799) == 0) k = KP;
        else if (r < 10) k = KS;
        else if (r < 20) k = KM;
        else if (r < 30) k = KW;
        else if (r < 33) k = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 59) == 0) lid = ~lid;
        cnt++;
        if (cnt >= half) begin
          cnt = 0;
          sec = ~sec;
          half = $urandom_range(1, 4);
        end
        cycle(k, lid, sec);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
